// File: rtl/apb_pkg.sv
// Shared types for the APB link between the requester (apb_master) and the
// memory responder. Holds the bus field widths, the FSM state encoding and
// the command struct carried on the requester's valid/ready port.
package apb_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = DATA_W / 8;

   localparam int APB_TIMEOUT_DEFAULT = 16;

   typedef logic [ADDR_W-1:0] addr_t;
   typedef logic [DATA_W-1:0] data_t;
   typedef logic [STRB_W-1:0] strb_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_t;

   typedef struct packed {
      addr_t paddr;
      logic  pwrite;
      data_t pwdata;
   } apb_req_t;

endpackage

// File: rtl/apb_master.sv
// apb_master: requester side of the APB link.
// Takes single-beat read/write commands on a valid/ready port, runs each as
// an APB SETUP + ACCESS transfer, and reports the result as a one-cycle
// response pulse. A PREADY watchdog aborts transfers against a hung
// responder so the requester always makes forward progress.
//
// Ports:
//   pclk, preset          clock (rising edge), async active-high reset
//   req_valid/req_ready   command handshake; req carries addr/write/wdata
//   req_strb              byte strobes for writes (forced to 0 for reads)
//   rsp_valid             one-cycle completion pulse, no backpressure
//   rsp_rdata/err/timeout read data (0 for writes/timeouts), error, abort
//   psel/penable/pwrite/paddr/pwdata/pstrb   APB request outputs
//   prdata/pready/pslverr                    APB responder inputs
module apb_master
   import apb_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = APB_TIMEOUT_DEFAULT
) (
   input  logic     pclk,
   input  logic     preset,
   input  logic     req_valid,
   output logic     req_ready,
   input  apb_req_t req,
   input  strb_t    req_strb,
   output logic     rsp_valid,
   output data_t    rsp_rdata,
   output logic     rsp_err,
   output logic     rsp_timeout,
   output logic     psel,
   output logic     penable,
   output logic     pwrite,
   output addr_t    paddr,
   output data_t    pwdata,
   output strb_t    pstrb,
   input  data_t    prdata,
   input  logic     pready,
   input  logic     pslverr
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   apb_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   addr_t            paddr_q, paddr_d;
   logic             pwrite_q, pwrite_d;
   data_t            pwdata_q, pwdata_d;
   strb_t            pstrb_q, pstrb_d;
   logic             rspValid_q, rspValid_d;
   data_t            rspRdata_q, rspRdata_d;
   logic             rspErr_q, rspErr_d;
   logic             rspTimeout_q, rspTimeout_d;
   logic             waitExpired;

   // The watchdog fires on the ACCESS cycle whose wait would bring the
   // counter up to the limit, so the bus sees exactly TIMEOUT_CYCLES
   // ACCESS cycles before psel drops. pready in that same cycle still wins.
   assign waitExpired = (TIMEOUT_CYCLES > 0) && (int'(cnt_q) + 1 >= TIMEOUT_CYCLES);

   // Next-state and response logic. A command can be taken either from IDLE
   // or in the completing ACCESS cycle (req_ready follows pready there),
   // which lets back-to-back transfers skip IDLE and keep psel high.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      paddr_d      = paddr_q;
      pwrite_d     = pwrite_q;
      pwdata_d     = pwdata_q;
      pstrb_d      = pstrb_q;
      rspValid_d   = 1'b0;
      rspRdata_d   = rspRdata_q;
      rspErr_d     = rspErr_q;
      rspTimeout_d = rspTimeout_q;
      req_ready    = 1'b0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
         end
         SETUP: begin
            state_d = ACCESS;
         end
         ACCESS: begin
            req_ready = pready;
            if (pready) begin
               state_d      = IDLE;
               rspValid_d   = 1'b1;
               rspErr_d     = pslverr;
               rspTimeout_d = 1'b0;
               rspRdata_d   = pwrite_q ? '0 : prdata;
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (waitExpired) begin
                  state_d      = IDLE;
                  rspValid_d   = 1'b1;
                  rspErr_d     = 1'b1;
                  rspTimeout_d = 1'b1;
                  rspRdata_d   = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (req_valid && req_ready) begin
         state_d  = SETUP;
         cnt_d    = '0;
         paddr_d  = req.paddr;
         pwrite_d = req.pwrite;
         pwdata_d = req.pwdata;
         pstrb_d  = req.pwrite ? req_strb : '0;
      end
   end

   // State, captured command and response registers. Reset clears
   // everything so an in-flight transfer is simply dropped.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         paddr_q      <= '0;
         pwrite_q     <= 1'b0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         rspValid_q   <= 1'b0;
         rspRdata_q   <= '0;
         rspErr_q     <= 1'b0;
         rspTimeout_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         paddr_q      <= paddr_d;
         pwrite_q     <= pwrite_d;
         pwdata_q     <= pwdata_d;
         pstrb_q      <= pstrb_d;
         rspValid_q   <= rspValid_d;
         rspRdata_q   <= rspRdata_d;
         rspErr_q     <= rspErr_d;
         rspTimeout_q <= rspTimeout_d;
      end
   end

   // APB control decodes straight from the state flop, so reset pulls
   // psel/penable low immediately without waiting for a clock edge.
   assign psel        = (state_q != IDLE);
   assign penable     = (state_q == ACCESS);
   assign pwrite      = pwrite_q;
   assign paddr       = paddr_q;
   assign pwdata      = pwdata_q;
   assign pstrb       = pstrb_q;
   assign rsp_valid   = rspValid_q;
   assign rsp_rdata   = rspRdata_q;
   assign rsp_err     = rspErr_q;
   assign rsp_timeout = rspTimeout_q;

endmodule
